// File: rtl/fp_sig_unpack_pipe.sv
// Two-stage pipelined significand unpacker for half/single/native operands.
// S1 selects fields, classifies and counts leading zeros; S2 normalises with a log shifter.
module fp_sig_unpack_pipe #(
    parameter int EW = 11,
    parameter int FW = 52,
    localparam int N   = 1 + EW + FW,
    localparam int LZW = $clog2(FW + 2)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     fmt,
    input  logic [N-1:0]   fp,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           sign,
    output logic [EW-1:0]  exp,
    output logic [FW-1:0]  h,
    output logic [FW:0]    sig,
    output logic [LZW-1:0] lz,
    output logic           is_zero,
    output logic           is_sub,
    output logic           is_inf,
    output logic           is_nan,
    output logic           fz,
    output logic           err
);

    logic           sel_sign;
    logic [EW-1:0]  sel_exp;
    logic [FW-1:0]  sel_h;
    logic           sel_eones;
    logic           sel_err;
    logic           sel_hidden;
    logic           sel_fzero;
    logic           sel_ezero;
    logic           sel_zero, sel_sub, sel_inf, sel_nan, sel_fz;
    logic [FW:0]    sel_sig;
    logic [LZW-1:0] lz_calc;

    logic           s1_v_reg;
    logic           s1_sign_reg;
    logic [EW-1:0]  s1_exp_reg;
    logic [FW:0]    s1_sig_reg;
    logic [LZW-1:0] s1_lz_reg;
    logic           s1_zero_reg, s1_sub_reg, s1_inf_reg, s1_nan_reg;
    logic           s1_fz_reg, s1_err_reg;

    logic           s2_rdy;
    logic [FW:0]    shf [LZW+1];

    assign s2_rdy   = !out_valid || out_ready;
    assign in_ready = !s1_v_reg || s2_rdy;

    // Field select; the all-ones exponent test uses the format's own exponent width.
    always_comb begin
        sel_sign  = 1'b0;
        sel_exp   = '0;
        sel_h     = '0;
        sel_eones = 1'b0;
        sel_err   = 1'b0;
        case (fmt)
            2'b00: begin
                sel_sign  = fp[15];
                sel_exp   = EW'(fp[14:10]);
                sel_h     = FW'(fp[9:0]) << (FW - 10);
                sel_eones = &fp[14:10];
            end
            2'b01: begin
                sel_sign  = fp[31];
                sel_exp   = EW'(fp[30:23]);
                sel_h     = FW'(fp[22:0]) << (FW - 23);
                sel_eones = &fp[30:23];
            end
            2'b10: begin
                sel_sign  = fp[N-1];
                sel_exp   = fp[N-2:FW];
                sel_h     = fp[FW-1:0];
                sel_eones = &fp[N-2:FW];
            end
            default: sel_err = 1'b1;
        endcase
    end

    // A reserved format zeroes every field, so flags are masked to keep err the only output set.
    assign sel_ezero  = (sel_exp == '0);
    assign sel_fzero  = (sel_h == '0);
    assign sel_hidden = !sel_ezero && !sel_eones;
    assign sel_zero   = !sel_err && sel_ezero && sel_fzero;
    assign sel_sub    = !sel_err && sel_ezero && !sel_fzero;
    assign sel_inf    = sel_eones && sel_fzero;
    assign sel_nan    = sel_eones && !sel_fzero;
    assign sel_fz     = !sel_err && sel_fzero;
    assign sel_sig    = {sel_hidden, sel_h};

    always_comb begin
        lz_calc = '0;
        for (int i = 0; i <= FW; i++) begin
            if (sel_sig[i]) begin
                lz_calc = LZW'(FW - i);
            end
        end
        if (!sel_sub) begin
            lz_calc = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_reg    <= 1'b0;
            s1_sign_reg <= 1'b0;
            s1_exp_reg  <= '0;
            s1_sig_reg  <= '0;
            s1_lz_reg   <= '0;
            s1_zero_reg <= 1'b0;
            s1_sub_reg  <= 1'b0;
            s1_inf_reg  <= 1'b0;
            s1_nan_reg  <= 1'b0;
            s1_fz_reg   <= 1'b0;
            s1_err_reg  <= 1'b0;
        end else if (in_ready) begin
            s1_v_reg <= in_valid;
            if (in_valid) begin
                s1_sign_reg <= sel_sign;
                s1_exp_reg  <= sel_exp;
                s1_sig_reg  <= sel_sig;
                s1_lz_reg   <= lz_calc;
                s1_zero_reg <= sel_zero;
                s1_sub_reg  <= sel_sub;
                s1_inf_reg  <= sel_inf;
                s1_nan_reg  <= sel_nan;
                s1_fz_reg   <= sel_fz;
                s1_err_reg  <= sel_err;
            end
        end
    end

    // Logarithmic left shifter: stage gi shifts by 2**gi when lz bit gi is set.
    assign shf[0] = s1_sig_reg;
    generate
        for (genvar gi = 0; gi < LZW; gi++) begin : g_shift
            assign shf[gi+1] = s1_lz_reg[gi] ? (shf[gi] << (2 ** gi)) : shf[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sign      <= 1'b0;
            exp       <= '0;
            h         <= '0;
            sig       <= '0;
            lz        <= '0;
            is_zero   <= 1'b0;
            is_sub    <= 1'b0;
            is_inf    <= 1'b0;
            is_nan    <= 1'b0;
            fz        <= 1'b0;
            err       <= 1'b0;
        end else if (s2_rdy) begin
            out_valid <= s1_v_reg;
            if (s1_v_reg) begin
                sign    <= s1_sign_reg;
                exp     <= s1_exp_reg;
                h       <= s1_sig_reg[FW-1:0];
                sig     <= shf[LZW];
                lz      <= s1_lz_reg;
                is_zero <= s1_zero_reg;
                is_sub  <= s1_sub_reg;
                is_inf  <= s1_inf_reg;
                is_nan  <= s1_nan_reg;
                fz      <= s1_fz_reg;
                err     <= s1_err_reg;
            end
        end
    end

endmodule

// File: tb/tb_fp_sig_unpack_pipe.sv
// Self-checking bench for fp_sig_unpack_pipe: directed vectors, stall/ordering,
// mid-operation reset and a randomized run against an arithmetic reference model.
module tb_fp_sig_unpack_pipe;

    typedef struct packed {
        logic        sign;
        logic [10:0] exp;
        logic [51:0] h;
        logic [52:0] sig;
        logic [5:0]  lz;
        logic        is_zero;
        logic        is_sub;
        logic        is_inf;
        logic        is_nan;
        logic        fz;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  fmt = 2'b00;
    logic [63:0] fp = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sign;
    logic [10:0] exp;
    logic [51:0] h;
    logic [52:0] sig;
    logic [5:0]  lz;
    logic        is_zero, is_sub, is_inf, is_nan, fz, err;
    res_t        dut_res;

    int errors = 0;
    int checks = 0;

    fp_sig_unpack_pipe #(.EW(11), .FW(52)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .fp(fp), .out_valid(out_valid), .out_ready(out_ready),
        .sign(sign), .exp(exp), .h(h), .sig(sig), .lz(lz),
        .is_zero(is_zero), .is_sub(is_sub), .is_inf(is_inf), .is_nan(is_nan),
        .fz(fz), .err(err)
    );

    always #5 clk = ~clk;

    assign dut_res = {sign, exp, h, sig, lz, is_zero, is_sub, is_inf, is_nan, fz, err};

    // Reference: decode by format widths, classify, then normalise by repeated doubling.
    function automatic res_t model(input logic [1:0] f, input logic [63:0] x);
        res_t        r;
        int          ew, fw;
        logic [63:0] e, fr, emax, fr_al;
        logic [52:0] m;
        r = '0;
        if (f == 2'b11) begin
            r.err = 1'b1;
            return r;
        end
        ew    = (f == 2'b00) ? 5 : (f == 2'b01) ? 8 : 11;
        fw    = (f == 2'b00) ? 10 : (f == 2'b01) ? 23 : 52;
        emax  = (64'd1 << ew) - 64'd1;
        e     = (x >> fw) & emax;
        fr    = x & ((64'd1 << fw) - 64'd1);
        fr_al = fr << (52 - fw);
        r.sign = x[ew + fw];
        r.exp  = e[10:0];
        r.h    = fr_al[51:0];
        r.fz   = (fr == 0);
        r.is_zero = (e == 0) && (fr == 0);
        r.is_sub  = (e == 0) && (fr != 0);
        r.is_inf  = (e == emax) && (fr == 0);
        r.is_nan  = (e == emax) && (fr != 0);
        m = {(e != 0) && (e != emax), r.h};
        if (r.is_sub) begin
            while (!m[52]) begin
                m = m << 1;
                r.lz = r.lz + 6'd1;
            end
        end
        r.sig = m;
        return r;
    endfunction

    function automatic logic [63:0] rand_op(input logic [1:0] f);
        logic [63:0] x, emask, fmask;
        int ew, fw;
        ew = (f == 2'b00) ? 5 : (f == 2'b01) ? 8 : 11;
        fw = (f == 2'b00) ? 10 : (f == 2'b01) ? 23 : 52;
        x = {$urandom, $urandom};
        fmask = (64'd1 << fw) - 64'd1;
        emask = ((64'd1 << ew) - 64'd1) << fw;
        case ($urandom_range(0, 5))
            1: x = x & ~emask;
            2: x = x | emask;
            3: x = (x & ~emask & ~fmask) | (64'd1 << $urandom_range(0, fw - 1));
            4: x = x & ~fmask;
            default: ;
        endcase
        return x;
    endfunction

    // Send one operand into an empty pipeline and capture the result; lat = cycles to out_valid.
    task automatic send_get(input logic [1:0] f, input logic [63:0] x, output res_t r, output int lat);
        @(negedge clk);
        fmt = f;
        fp = x;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        r = '0;
        lat = -1;
        if (in_ready) begin
            @(posedge clk);
            lat = 0;
            while (lat < 10) begin
                @(negedge clk);
                in_valid = 1'b0;
                lat++;
                if (out_valid) break;
            end
            r = dut_res;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        in_valid = 1'b1;
        fmt = 2'b10;
        fp = 64'h3FF8000000000000;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || dut_res !== '0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b data=%h required 0/0", out_valid, dut_res);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignored_input: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_native;
        res_t r, e;
        int   lat;
        send_get(2'b10, 64'h3FF8000000000000, r, lat);
        e = '0;
        e.exp = 11'h3FF;
        e.h   = 52'h8000000000000;
        e.sig = 53'h18000000000000;
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL native_latency: got %0d required 2", lat);
        end
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL native_normal: got %h required %h", r, e);
        end
        send_get(2'b10, 64'h0000000000000001, r, lat);
        e = '0;
        e.is_sub = 1'b1;
        e.h   = 52'h1;
        e.lz  = 6'd52;
        e.sig = 53'h10000000000000;
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL native_min_sub: got %h required %h", r, e);
        end
    endtask

    task automatic test_single_half;
        res_t r, e;
        int   lat;
        send_get(2'b01, 64'h000000003F800000, r, lat);
        e = '0;
        e.exp = 11'h07F;
        e.fz  = 1'b1;
        e.sig = 53'h10000000000000;
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL single_one: got %h required %h", r, e);
        end
        send_get(2'b01, 64'h000000007F800001, r, lat);
        e = '0;
        e.exp = 11'h0FF;
        e.is_nan = 1'b1;
        e.h   = 52'h20000000;
        e.sig = 53'h20000000;
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL single_nan: got %h required %h", r, e);
        end
        e = '0;
        e.is_sub = 1'b1;
        e.h   = 52'h8000000000000;
        e.lz  = 6'd1;
        e.sig = 53'h10000000000000;
        send_get(2'b00, 64'h0000000000000200, r, lat);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL half_sub: got %h required %h", r, e);
        end
        send_get(2'b00, 64'hDEADBEEF12340200, r, lat);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL half_upper_ignored: got %h required %h", r, e);
        end
        send_get(2'b11, 64'hFFFFFFFFFFFFFFFF, r, lat);
        e = '0;
        e.err = 1'b1;
        checks++;
        if (r !== e || lat !== 2) begin
            errors++;
            $display("FAIL reserved_fmt: got %h lat %0d required %h lat 2", r, lat, e);
        end
    endtask

    task automatic test_boundaries;
        logic [1:0]  tf [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
        logic [63:0] tx [6] = '{64'h7C00, 64'hFC01, 64'h80000000, 64'h00000001,
                                64'h7FF0000000000000, 64'h000FFFFFFFFFFFFF};
        res_t r, e;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            send_get(tf[i], tx[i], r, lat);
            e = model(tf[i], tx[i]);
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL boundary_%0d: got %h required %h", i, r, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] ops [3] = '{64'h4000000000000000, 64'h0008000000000000, 64'hC010000000000000};
        res_t exp_q [3];
        int   sent = 0, recv = 0;
        for (int i = 0; i < 3; i++) exp_q[i] = model(2'b10, ops[i]);
        fmt = 2'b10;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid = (sent < 3);
            fp = ops[(sent < 3) ? sent : 2];
            #1;
            if (cyc == 2) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_backpressure: in_ready=%b required 0", in_ready);
                end
            end
            if (cyc >= 2 && cyc < 5) begin
                checks++;
                if (out_valid !== 1'b1 || dut_res !== exp_q[0]) begin
                    errors++;
                    $display("FAIL b2b_stall_hold: valid=%b got %h required %h", out_valid, dut_res, exp_q[0]);
                end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                checks++;
                if (recv >= 3 || dut_res !== exp_q[(recv < 3) ? recv : 2]) begin
                    errors++;
                    $display("FAIL b2b_order_%0d: got %h required %h", recv, dut_res, exp_q[(recv < 3) ? recv : 2]);
                end
                recv++;
            end
            @(posedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (recv !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d results required 3", recv);
        end
    endtask

    task automatic test_reset_midop;
        res_t r, e;
        int   lat;
        out_ready = 1'b0;
        fmt = 2'b10;
        @(negedge clk);
        in_valid = 1'b1;
        fp = 64'h3FF0000000000000;
        @(posedge clk);
        @(negedge clk);
        fp = 64'h4008000000000000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midop_full: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dut_res !== '0) begin
            errors++;
            $display("FAIL midop_async_clear: out_valid=%b data=%h required 0/0", out_valid, dut_res);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midop_stale_%0d: out_valid=%b required 0", i, out_valid);
            end
        end
        send_get(2'b01, 64'h00000000C0490FDB, r, lat);
        e = model(2'b01, 64'h00000000C0490FDB);
        checks++;
        if (r !== e || lat !== 2) begin
            errors++;
            $display("FAIL midop_after: got %h lat %0d required %h lat 2", r, lat, e);
        end
    endtask

    task automatic test_random;
        res_t        q [$];
        res_t        e, prev_res;
        logic        stalled = 1'b0;
        logic [1:0]  nf;
        logic [63:0] nx;
        int          sent = 0, recv = 0, cyc = 0, sel;
        sel = $urandom_range(0, 15);
        nf = (sel < 5) ? 2'b00 : (sel < 10) ? 2'b01 : (sel < 15) ? 2'b10 : 2'b11;
        nx = rand_op(nf);
        while (recv < 1000 && cyc < 20000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            fmt = nf;
            fp = nx;
            #1;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || dut_res !== prev_res) begin
                    errors++;
                    $display("FAIL rand_stall_hold: valid=%b got %h required %h", out_valid, dut_res, prev_res);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(nf, nx));
                sent++;
                sel = $urandom_range(0, 15);
                nf = (sel < 5) ? 2'b00 : (sel < 10) ? 2'b01 : (sel < 15) ? 2'b10 : 2'b11;
                nx = rand_op(nf);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_result: got %h with empty scoreboard", dut_res);
                end else begin
                    e = q.pop_front();
                    if (dut_res !== e) begin
                        errors++;
                        $display("FAIL rand_op_%0d: got %h required %h", recv, dut_res, e);
                    end
                end
                recv++;
            end
            stalled = out_valid && !out_ready;
            prev_res = dut_res;
            @(posedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (recv !== 1000 || q.size() != 0) begin
            errors++;
            $display("FAIL rand_count: got %0d results, %0d pending, required 1000/0", recv, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_native();
        test_single_half();
        test_boundaries();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
